// File: rtl/accum_seq_ctrl.sv
// Purpose: sequences bit-plane partial sums into an accumulation buffer, then reads and clears the buffer to present the result.
// Latency: the result is valid 3 cycles after the last partial sum is accepted.
// Backpressure: psum_ready_o is high only in ACCUM; the result is held until result_ready_i or clear_i.
module accum_seq_ctrl #(
  parameter int unsigned NUM_PLANES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic        psum_valid_i,
  input  logic [15:0] psum_i,
  output logic        psum_ready_o,
  output logic        accum_buf_write_en_o,
  output logic [19:0] shifter_output_o,
  output logic        accum_buf_read_en_o,
  input  logic [31:0] accum_buf_output_i,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  input  logic        result_ready_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_READ,
    S_HOLD
  } state_t;

  localparam logic [2:0] LAST_PLANE = 3'(NUM_PLANES - 1);

  state_t     state;
  logic [2:0] plane_cnt;
  logic       discard;
  logic       do_write;

  // A psum produces a write only when accepted and not overridden by a same-cycle clear.
  assign do_write = (state == S_ACCUM) && psum_valid_i && !clear_i;

  // Handshake and strobes are decoded from the state register only, so no input reaches them combinationally.
  assign psum_ready_o        = (state == S_ACCUM);
  assign accum_buf_read_en_o = (state == S_READ);
  assign result_valid_o      = (state == S_HOLD);
  assign busy_o              = (state != S_IDLE);

  // Control FSM: plane counting, flush of the in-flight write, read/clear of the buffer, result hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      plane_cnt <= 3'd0;
      discard   <= 1'b0;
      result_o  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state     <= S_ACCUM;
            plane_cnt <= 3'd0;
          end
        end
        S_ACCUM: begin
          if (clear_i) begin
            // Abort: still pulse read_en once so the buffer is left zeroed.
            state   <= S_READ;
            discard <= 1'b1;
          end else if (psum_valid_i) begin
            plane_cnt <= plane_cnt + 3'd1;
            if (plane_cnt == LAST_PLANE) begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // One cycle lets the final registered write land before the read.
          state <= S_READ;
          if (clear_i) begin
            discard <= 1'b1;
          end
        end
        S_READ: begin
          if (discard) begin
            discard <= 1'b0;
            state   <= S_IDLE;
          end else begin
            result_o <= accum_buf_output_i;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (clear_i || result_ready_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered write path: shift each accepted psum by its plane index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accum_buf_write_en_o <= 1'b0;
      shifter_output_o     <= 20'd0;
    end else begin
      accum_buf_write_en_o <= do_write;
      shifter_output_o     <= do_write ? (20'(psum_i) << plane_cnt) : 20'd0;
    end
  end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
`timescale 1ns/1ps
// Randomized and directed stimulus against a sum-of-shifted-planes reference model,
// with an accumulation-buffer model and a scoreboard monitor on the DUT outputs.
module tb_accum_seq_ctrl;
  localparam int NP = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        psum_valid_i = 1'b0;
  logic [15:0] psum_i = 16'd0;
  logic        result_ready_i = 1'b0;
  logic        psum_ready_o;
  logic        accum_buf_write_en_o;
  logic [19:0] shifter_output_o;
  logic        accum_buf_read_en_o;
  logic [31:0] accum_buf_output_i;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic        busy_o;

  accum_seq_ctrl #(.NUM_PLANES(NP)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .start_i              (start_i),
    .clear_i              (clear_i),
    .psum_valid_i         (psum_valid_i),
    .psum_i               (psum_i),
    .psum_ready_o         (psum_ready_o),
    .accum_buf_write_en_o (accum_buf_write_en_o),
    .shifter_output_o     (shifter_output_o),
    .accum_buf_read_en_o  (accum_buf_read_en_o),
    .accum_buf_output_i   (accum_buf_output_i),
    .result_valid_o       (result_valid_o),
    .result_o             (result_o),
    .result_ready_i       (result_ready_i),
    .busy_o               (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_rd = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] held = 32'd0;
  logic [31:0] last_result = 32'd0;
  logic [31:0] buf_q;

  logic [19:0] wq[$];
  logic [31:0] rq[$];
  int          lat_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Accumulation buffer: adds on write, read returns contents and clears.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) buf_q <= 32'd0;
    else if (accum_buf_read_en_o) buf_q <= 32'd0;
    else if (accum_buf_write_en_o) buf_q <= buf_q + 32'(shifter_output_o);
  end
  assign accum_buf_output_i = accum_buf_read_en_o ? buf_q : 32'hDEAD_BEEF;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: compares DUT outputs against the expectation queues.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_valid = 1'b0;
    end else begin
      if (accum_buf_write_en_o) begin
        n_wr++;
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else chk("shifter_output", 32'(shifter_output_o), 32'(wq.pop_front()));
      end else if (shifter_output_o != 20'd0) begin
        chk("shifter_idle_zero", 32'(shifter_output_o), 0);
      end
      if (accum_buf_write_en_o && accum_buf_read_en_o) chk("wr_rd_overlap", 1, 0);
      if (accum_buf_read_en_o) n_rd++;
      if (result_valid_o) begin
        if (rq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          if (!prev_valid) begin
            chk("result_latency", cyc - lat_q[0], 3);
            held = result_o;
          end else begin
            chk("result_stable", result_o, held);
          end
          if (result_ready_i || clear_i) begin
            chk("result_o", result_o, rq.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      prev_valid = result_valid_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One accumulation. clear_idx: plane index to clear on, NP = clear in FLUSH, -1 = none.
  task automatic run_op(input logic [15:0] ps [NP], input int gmin, input int gmax,
                        input int clear_idx, input bit start_in_accum, input int hold_cycles,
                        input bit clear_hold, input bit clear_read);
    logic [31:0] exp_sum;
    logic [19:0] w;
    int wr0, rd0, acc_cyc, t, nwr_exp, gap;
    bit discarded;
    exp_sum = 0; nwr_exp = 0; discarded = 0; acc_cyc = 0;
    wr0 = n_wr; rd0 = n_rd;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < NP; i++) begin
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g < gap; g++) begin
        start_i = start_in_accum;
        tick();
        start_i = 1'b0;
      end
      psum_valid_i = 1'b1;
      psum_i = ps[i];
      clear_i = (i == clear_idx);
      t = 0;
      while (!psum_ready_o && t < 20) begin tick(); t++; end
      if (t == 20) chk("psum_ready_timeout", 0, 1);
      acc_cyc = cyc;
      if (i == clear_idx) begin
        discarded = 1;
      end else begin
        w = 20'(ps[i]);
        w = w << i;
        wq.push_back(w);
        exp_sum += 32'(ps[i]) << i;
        nwr_exp++;
      end
      tick();
      psum_valid_i = 1'b0;
      clear_i = 1'b0;
      if (discarded) break;
    end
    if (clear_idx == NP) begin
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      discarded = 1;
    end
    if (!discarded) begin
      rq.push_back(exp_sum);
      lat_q.push_back(acc_cyc);
      last_result = exp_sum;
      if (clear_read) begin
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
      end
      t = 0;
      while (!result_valid_o && t < 20) begin tick(); t++; end
      if (t == 20) chk("result_valid_timeout", 0, 1);
      for (int h = 0; h < hold_cycles; h++) tick();
      if (clear_hold) clear_i = 1'b1;
      else result_ready_i = 1'b1;
      tick();
      clear_i = 1'b0;
      result_ready_i = 1'b0;
      chk("valid_drop", 32'(result_valid_o), 0);
      chk("idle_after_ready", 32'(busy_o), 0);
    end else begin
      t = 0;
      while (busy_o && t < 20) begin tick(); t++; end
      chk("discard_idle", 32'(busy_o), 0);
      chk("discard_result_kept", result_o, last_result);
    end
    chk("write_count", n_wr - wr0, nwr_exp);
    chk("read_count", n_rd - rd0, 1);
    tick();
    tick();
    chk("no_queued_start", 32'(busy_o), 0);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_psum_ready"}, 32'(psum_ready_o), 0);
    chk({tag, "_write_en"}, 32'(accum_buf_write_en_o), 0);
    chk({tag, "_read_en"}, 32'(accum_buf_read_en_o), 0);
    chk({tag, "_result_valid"}, 32'(result_valid_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_shifter"}, 32'(shifter_output_o), 0);
    chk({tag, "_result"}, result_o, 0);
  endtask

  initial begin
    logic [15:0] v [NP];
    logic [19:0] w;
    int rd0, ci;
    #1;
    chk_zero_outputs("reset");
    tick();
    tick();
    rst_ni = 1'b1;

    // Psums 1,2,3,4 back-to-back; start accepted on first edge after reset release.
    v = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_op(v, 0, 0, -1, 1'b0, 0, 1'b0, 1'b0);
    // All-ones planes.
    v = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_op(v, 0, 0, -1, 1'b0, 0, 1'b0, 1'b0);
    // Two-cycle gaps with start pulsed during ACCUM.
    v = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_op(v, 2, 2, -1, 1'b1, 0, 1'b0, 1'b0);
    // Consumer stalls 5 cycles in HOLD.
    run_op(v, 0, 0, -1, 1'b0, 5, 1'b0, 1'b0);
    // Clear with the third accept, then a run of ones.
    v = '{16'd7, 16'd9, 16'd11, 16'd13};
    run_op(v, 0, 0, 2, 1'b0, 0, 1'b0, 1'b0);
    v = '{16'd1, 16'd1, 16'd1, 16'd1};
    run_op(v, 0, 0, -1, 1'b0, 0, 1'b0, 1'b0);
    // Clear in FLUSH, clear in READ (ignored), clear in HOLD.
    v = '{16'd100, 16'd200, 16'd300, 16'd400};
    run_op(v, 0, 1, NP, 1'b0, 0, 1'b0, 1'b0);
    run_op(v, 0, 1, -1, 1'b0, 0, 1'b0, 1'b1);
    run_op(v, 0, 1, -1, 1'b0, 2, 1'b1, 1'b0);

    // Reset asserted while in FLUSH.
    v = '{16'd5, 16'd6, 16'd7, 16'd8};
    rd0 = n_rd;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < NP; i++) begin
      psum_valid_i = 1'b1;
      psum_i = v[i];
      w = 20'(v[i]);
      w = w << i;
      wq.push_back(w);
      tick();
    end
    psum_valid_i = 1'b0;
    chk("flush_write_en", 32'(accum_buf_write_en_o), 1);
    rst_ni = 1'b0;
    #1;
    chk_zero_outputs("flush_reset");
    tick();
    tick();
    chk("reset_no_read", n_rd - rd0, 0);
    wq.delete();
    last_result = 32'd0;
    rst_ni = 1'b1;
    v = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_op(v, 0, 0, -1, 1'b0, 0, 1'b0, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NP; i++) v[i] = 16'($urandom);
      case ($urandom_range(7, 0))
        0: ci = $urandom_range(NP - 1, 0);
        1: ci = NP;
        default: ci = -1;
      endcase
      // Idle psum_valid must be ignored.
      psum_valid_i = 1'b1;
      psum_i = 16'($urandom);
      tick();
      psum_valid_i = 1'b0;
      run_op(v, 0, 3, ci, 1'($urandom_range(1, 0)), $urandom_range(3, 0),
             ($urandom_range(5, 0) == 0), ($urandom_range(4, 0) == 0));
    end

    chk("scoreboard_drained", rq.size() + wq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
